// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared ALU op codes, FSM state encoding and flag bit positions for the ALU arbiter.
package alu_arbiter_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'hB;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    function automatic logic [2:0] pack_flags(input logic v, input logic c, input logic z);
        logic [2:0] f;
        f = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// alu_arbiter_rr: combinational round-robin pick; first set request at or after ptr wins.
module alu_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    int c;
    logic [IW-1:0] ci;

    always_comb begin
        grant = '0;
        idx = '0;
        any = 1'b0;
        c = 0;
        ci = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            c = (c >= NUM_REQ) ? c - NUM_REQ : c;
            ci = IW'(c);
            if (!any && req[ci]) begin
                grant[ci] = 1'b1;
                idx = ci;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one registered ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester response counters on stat_count.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W = ALU_W
) (
`ifdef ALU_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] stat_count,
`endif
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0] req_op,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 alu_enable,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [3:0]           alu_op_code,
    input  logic [W-1:0]         alu_result,
    input  logic                 alu_zero_flag,
    input  logic                 alu_carry_flag,
    input  logic                 alu_overflow_flag
);

    localparam int IW = $clog2(NUM_REQ);

    state_t state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic [W-1:0] result_q, result_d;
    logic [2:0] flags_q, flags_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0] arb_idx;
    logic arb_any;

    alu_arbiter_rr #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    logic rsp_hs;
    assign rsp_hs = (state_q == RESP) && rsp_ready[gnt_q];

    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        gnt_d = gnt_q;
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    alu_a_d = req_a[arb_idx*W +: W];
                    alu_b_d = req_b[arb_idx*W +: W];
                    alu_op_d = req_op[arb_idx*4 +: 4];
                    gnt_d = arb_idx;
                    rr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                result_d = alu_result;
                flags_d = pack_flags(alu_overflow_flag, alu_carry_flag, alu_zero_flag);
                state_d = RESP;
            end
            default: state_d = rsp_hs ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q <= '0;
            gnt_q <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            gnt_q <= gnt_d;
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
            flags_q <= flags_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? arb_grant : '0;
    assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign alu_enable = (state_q == ISSUE);
    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;
    assign alu_op_code = alu_op_q;
    assign rsp_result = result_q;
    assign rsp_flags = flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (rsp_hs && stat_q[gnt_q*16 +: 16] != 16'hFFFF)
            stat_d[gnt_q*16 +: 16] = stat_q[gnt_q*16 +: 16] + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stat_q <= '0;
        else stat_q <= stat_d;
    end

    assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven ops plus contention, backpressure and reset sequences against a stub ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic [15:0] req_op = '0;
    logic [15:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0] rsp_flags;
    logic alu_enable, alu_zero_flag, alu_carry_flag, alu_overflow_flag;
    logic [3:0] alu_op_code;
`ifdef ALU_ARB_STATS_EN
    logic [63:0] stat_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
`ifdef ALU_ARB_STATS_EN
        .stat_count        (stat_count),
`endif
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_op            (req_op),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_result        (rsp_result),
        .rsp_flags         (rsp_flags),
        .alu_enable        (alu_enable),
        .alu_a             (alu_a),
        .alu_b             (alu_b),
        .alu_op_code       (alu_op_code),
        .alu_result        (alu_result),
        .alu_zero_flag     (alu_zero_flag),
        .alu_carry_flag    (alu_carry_flag),
        .alu_overflow_flag (alu_overflow_flag)
    );

    // Stub of the external registered ALU: outputs update only on an enabled edge.
    logic [15:0] m_r;
    logic m_c, m_v;
    logic [16:0] sum;
    logic [15:0] diff;
    logic [31:0] prod;

    always_comb begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        diff = alu_a - alu_b;
        prod = {16'd0, alu_a} * {16'd0, alu_b};
        m_r = '0;
        m_c = 1'b0;
        m_v = 1'b0;
        case (alu_op_code)
            OP_ADD: begin
                m_r = sum[15:0];
                m_c = sum[16];
                m_v = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
            end
            OP_SUB: begin
                m_r = diff;
                m_c = alu_a < alu_b;
                m_v = (alu_a[15] != alu_b[15]) && (diff[15] != alu_a[15]);
            end
            OP_MUL: begin
                m_r = prod[15:0];
                m_c = |prod[31:16];
                m_v = |prod[31:16];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= '0;
            alu_carry_flag <= 1'b0;
            alu_overflow_flag <= 1'b0;
            alu_zero_flag <= 1'b1;
        end else if (alu_enable) begin
            alu_result <= m_r;
            alu_carry_flag <= m_c;
            alu_overflow_flag <= m_v;
            alu_zero_flag <= (m_r == 16'd0);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; runs one op on requester r with rsp_ready high and checks its timeline.
    task automatic run_op(input int r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [2:0] ef, input string nm);
        int n;
        req_a[r*16 +: 16] = a;
        req_b[r*16 +: 16] = b;
        req_op[r*4 +: 4] = op;
        req_valid = 4'b0001 << r;
        rsp_ready = '1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " req_ready"}, req_ready, 4'b0001 << r);
        @(negedge clk);
        req_valid = '0;
        check({nm, " alu_enable c1"}, alu_enable, 1);
        check({nm, " alu_a/b/op"}, {alu_a, alu_b, alu_op_code}, {a, b, op});
        @(negedge clk);
        check({nm, " alu_enable c2"}, alu_enable, 0);
        check({nm, " rsp_valid c2"}, rsp_valid, 0);
        @(negedge clk);
        check({nm, " rsp_valid c3"}, rsp_valid, 4'b0001 << r);
        check({nm, " rsp_result"}, rsp_result, er);
        check({nm, " rsp_flags"}, rsp_flags, ef);
        @(negedge clk);
        check({nm, " rsp_valid done"}, rsp_valid, 0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int r;
        logic [3:0] op;
        logic [15:0] a, b, er;
        logic [2:0] ef;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, cyc;
        vecs[0] = '{1, OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b100};
        vecs[1] = '{0, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 3'b111};
        vecs[2] = '{3, 4'hF,   16'h1234, 16'h5678, 16'h0000, 3'b001};
        vecs[3] = '{2, OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 3'b010};
        vecs[4] = '{0, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b011};
        vecs[5] = '{3, OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 3'b100};
        vecs[6] = '{1, OP_MUL, 16'h0003, 16'h0005, 16'h000F, 3'b000};
        vecs[7] = '{2, 4'hC,   16'h0005, 16'h0007, 16'h0000, 3'b001};

        repeat (3) @(negedge clk);
        check("reset outputs", {req_ready, rsp_valid, alu_enable}, 0);
        check("reset regs", {alu_a, alu_b, alu_op_code, rsp_result, rsp_flags}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ef, $sformatf("vec%0d", i));

        // Contention: all four requesting, fresh pointer, order 0,1,2,3,0 one grant per 4 cycles.
        do_reset();
        rsp_ready = '1;
        req_valid = '1;
        #1;
        cyc = 0;
        for (int g = 0; g < 5; g++) begin
            while (req_ready == 0 && cyc < 20) begin
                if (rsp_valid != 0) check("cont rsp_valid", rsp_valid, 4'b0001 << ((g + 3) % 4));
                @(negedge clk);
                cyc++;
            end
            check($sformatf("cont grant%0d", g), req_ready, 4'b0001 << (g % 4));
            if (g > 0) check($sformatf("cont spacing%0d", g), cyc, 4);
            @(negedge clk);
            cyc = 1;
        end
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Backpressure on requester 2 while requester 0 waits.
        req_a[32 +: 16] = 16'h0001;
        req_b[32 +: 16] = 16'h0002;
        req_op[8 +: 4] = OP_SUB;
        req_valid = 4'b0100;
        rsp_ready = 4'b1011;
        #1;
        n = 0;
        while (!req_ready[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp rsp_valid held", rsp_valid, 4'b0100);
            check("bp result/flags", {rsp_result, rsp_flags}, {16'hFFFF, 3'b010});
            check("bp no req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = '1;
        @(negedge clk);
        check("bp released", rsp_valid, 0);
        check("bp next grant", req_ready, 4'b0001);
        req_valid = '0;
        #1;
        check("drop valid ready", req_ready, 0);
        @(negedge clk);
        check("drop valid no issue", {alu_enable, req_ready}, 0);

        // Async reset while a response is pending; pointer must return to 0.
        run_op(2, OP_ADD, 16'h0002, 16'h0003, 16'h0005, 3'b000, "pre-reset");
        req_a[16 +: 16] = 16'h0004;
        req_b[16 +: 16] = 16'h0004;
        req_op[4 +: 4] = OP_ADD;
        req_valid = 4'b0010;
        rsp_ready = '0;
        #1;
        n = 0;
        while (!req_ready[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("rst pre rsp_valid", rsp_valid, 4'b0010);
        #1 reset_n = 1'b0;
        #1;
        check("rst async outputs", {rsp_valid, alu_enable, req_ready}, 0);
        check("rst async regs", {alu_a, alu_b, alu_op_code, rsp_result, rsp_flags}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst no stale rsp", rsp_valid, 0);
        req_a[0 +: 16] = 16'h0010;
        req_b[0 +: 16] = 16'h0020;
        req_op[0 +: 4] = OP_ADD;
        req_valid = '1;
        rsp_ready = '1;
        #1;
        check("rst first grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("rst first rsp", {rsp_valid, rsp_result, rsp_flags}, {4'b0001, 16'h0030, 3'b000});
        @(negedge clk);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        check("stats cleared", stat_count, 0);
        for (int i = 0; i < 3; i++) run_op(0, OP_ADD, 16'd1, 16'd1, 16'd2, 3'b000, "stat r0");
        run_op(3, OP_ADD, 16'd0, 16'd0, 16'd0, 3'b001, "stat r3");
        check("stats counts", stat_count, {16'd1, 16'd0, 16'd0, 16'd3});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
